// File: rtl/instr_encoder_loader_pkg.sv
// RV32 field-level request types, opcode constants and the encode/decode immediate helpers
// shared by the instruction loader and its decode-side counterpart.
package instr_encoder_loader_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } encoding_type;

    typedef logic [XLEN-1:0] instruction_type;

    localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        encoding_type     encoding;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } instr_request_type;

    // Inverse of immediate_extension; B uses the unscaled 12-bit layout of the decode path.
    function automatic instruction_type encode_instruction(input instr_request_type r);
        instruction_type w;
        w       = '0;
        w[6:0]  = r.opcode;
        case (r.encoding)
            R_TYPE:  w[31:7] = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd};
            I_TYPE:  w[31:7] = {r.imm[11:0], r.rs1, r.funct3, r.rd};
            S_TYPE:  w[31:7] = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0]};
            B_TYPE:  w[31:7] = {r.imm[11], r.imm[9:4], r.rs2, r.rs1, r.funct3,
                                r.imm[3:0], r.imm[10]};
            U_TYPE:  w[31:7] = {r.imm[31:12], r.rd};
            J_TYPE:  w[31:7] = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd};
            default: w[31:7] = '0;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] immediate_extension(input instruction_type w,
                                                            input encoding_type enc);
        logic [XLEN-1:0] imm;
        case (enc)
            I_TYPE:  imm = {{20{w[31]}}, w[31:20]};
            S_TYPE:  imm = {{20{w[31]}}, w[31:25], w[11:7]};
            B_TYPE:  imm = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            U_TYPE:  imm = {w[31:12], 12'h000};
            J_TYPE:  imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instruction_packer.sv
// Combinational field-to-word packer; with ENCODER_CHECK_EN it also flags immediates
// that would not survive the decode-side sign extension.
module instruction_packer
    import instr_encoder_loader_pkg::*;
(
    input  instr_request_type req_i,
    output instruction_type   word_c
`ifdef ENCODER_CHECK_EN
    ,
    output logic              range_ok_c
`endif
);

    assign word_c = encode_instruction(req_i);

`ifdef ENCODER_CHECK_EN
    logic [20:0] isb_hi_c;
    logic [11:0] j_hi_c;

    assign isb_hi_c = req_i.imm[31:11];
    assign j_hi_c   = req_i.imm[31:20];

    // Upper bits must be a pure sign run so the decoder reproduces the same value.
    always_comb begin
        range_ok_c = 1'b1;
        case (req_i.encoding)
            I_TYPE, S_TYPE, B_TYPE: range_ok_c = (&isb_hi_c) | ~(|isb_hi_c);
            J_TYPE:                 range_ok_c = ((&j_hi_c) | ~(|j_hi_c)) & ~req_i.imm[0];
            U_TYPE:                 range_ok_c = ~(|req_i.imm[11:0]);
            default:                range_ok_c = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level requests into RV32 words and streams them into instruction memory.
// Optional accept-time immediate range check and err pulse under ENCODER_CHECK_EN.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  instr_request_type      req,
    input  logic                   req_last,
    input  logic                   clear,
    output logic                   imem_we,
    input  logic                   imem_ready,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [XLEN-1:0]        imem_wdata,
    output logic [ADDR_W:0]        count,
    output logic                   full,
`ifdef ENCODER_CHECK_EN
    output logic                   err,
`endif
    output logic                   done
);

    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                done_q, done_d;

    instruction_type     word_c;
    logic                range_ok_c;
    logic                accept_c;
    logic                load_c;
    logic                complete_c;
    logic                room_c;

`ifdef ENCODER_CHECK_EN
    logic                err_q, err_d;

    instruction_packer u_packer (
        .req_i      (req),
        .word_c     (word_c),
        .range_ok_c (range_ok_c)
    );
`else
    instruction_packer u_packer (
        .req_i  (req),
        .word_c (word_c)
    );

    assign range_ok_c = 1'b1;
`endif

    // Room exists only if the pending word plus a new one still fits within DEPTH.
    assign room_c     = (count_q + CNT_W'(we_q)) < DEPTH_C;
    assign complete_c = we_q && imem_ready;
    assign req_ready  = reset_n && (state_q != FULL) && (!we_q || imem_ready)
                        && !clear && room_c;
    assign accept_c   = req_valid && req_ready;
    assign load_c     = accept_c && range_ok_c;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = 1'b0;
`ifdef ENCODER_CHECK_EN
        err_d   = 1'b0;
`endif

        if (clear) begin
            // Restart wins over any pending write; the held word is dropped.
            state_d = IDLE;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            last_d  = 1'b0;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            if (complete_c) begin
                we_d   = 1'b0;
                done_d = last_q;
                if (count_q != DEPTH_C) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            if (load_c) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(count_d);
                wdata_d = word_c;
                last_d  = req_last;
            end
`ifdef ENCODER_CHECK_EN
            err_d = accept_c && !range_ok_c;
`endif

            full_d = (count_d == DEPTH_C);

            case (state_q)
                IDLE: begin
                    if (load_c) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (complete_c && (count_d == DEPTH_C)) begin
                        state_d = FULL;
                    end else if (complete_c && last_q && !load_c) begin
                        state_d = IDLE;
                    end
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENCODER_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
`ifdef ENCODER_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign done       = done_q;
`ifdef ENCODER_CHECK_EN
    assign err        = err_q;
`endif

endmodule
